// File: rtl/fft_pkg.sv
// Shared definitions for the FFT front-end blocks: sizes, mode encodings,
// FSM state type and index helpers.
package fft_pkg;

  localparam int FFT_WIDTH = 16;
  localparam int FFT_DEPTH = 16;
  localparam int IDXW      = 4;

  localparam logic [1:0] MODE_N4  = 2'b00;
  localparam logic [1:0] MODE_N8  = 2'b01;
  localparam logic [1:0] MODE_N16 = 2'b10;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_HOLD    = 1'b1
  } state_t;

  // FFT length for a mode; 2'b11 is a reserved alias of 16.
  function automatic logic [4:0] fft_len(input logic [1:0] mode);
    logic [4:0] n;
    case (mode)
      MODE_N4: n = 5'd4;
      MODE_N8: n = 5'd8;
      default: n = 5'd16;
    endcase
    return n;
  endfunction

  function automatic logic [2:0] fft_log2n(input logic [1:0] mode);
    logic [2:0] l;
    case (mode)
      MODE_N4: l = 3'd2;
      MODE_N8: l = 3'd3;
      default: l = 3'd4;
    endcase
    return l;
  endfunction

  // Reverse the low log2n bits of idx; upper bits come back as zero.
  function automatic logic [IDXW-1:0] bit_reverse(input logic [IDXW-1:0] idx,
                                                  input logic [2:0]      log2n);
    logic [IDXW-1:0] r;
    case (log2n)
      3'd2:    r = {2'b00, idx[0], idx[1]};
      3'd3:    r = {1'b0, idx[0], idx[1], idx[2]};
      default: r = {idx[0], idx[1], idx[2], idx[3]};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fft_bitrev_index.sv
// Maps a running sample count to its frame slot, natural or bit-reversed
// over the active FFT length.
module fft_bitrev_index
  import fft_pkg::*;
(
  input  logic [IDXW-1:0] count,
  input  logic [1:0]      mode,
  input  logic            bitrev_en,
  output logic [IDXW-1:0] slot
);

  logic [IDXW-1:0] w_rev;

  // Purely combinational slot selection.
  always_comb begin
    w_rev = bit_reverse(count, fft_log2n(mode));
    slot  = bitrev_en ? w_rev : count;
  end

endmodule

// File: rtl/fft_frame_collector.sv
// Collects a serial stream of complex samples into one flattened frame and
// holds it until the downstream register bank takes it.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_COLLECT | accepting samples; buffer filling from a zeroed start
// ST_HOLD    | frame complete and presented; waiting for frame_ready
module fft_frame_collector
  import fft_pkg::*;
#(
  parameter int WIDTH = FFT_WIDTH,
  parameter int DEPTH = FFT_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_real,
  input  logic [WIDTH-1:0]       in_imag,
  input  logic [1:0]             mode,
  input  logic                   bitrev_en,
  output logic                   frame_valid,
  input  logic                   frame_ready,
  output logic [WIDTH*DEPTH-1:0] frame_real,
  output logic [WIDTH*DEPTH-1:0] frame_imag,
  output logic [1:0]             frame_mode
);

  state_t          r_state;
  logic [IDXW-1:0] r_count;
  logic [1:0]      r_mode;
  logic            r_bitrev;
  logic            r_in_ready;
  logic            r_frame_valid;
  logic [WIDTH-1:0] r_real [DEPTH];
  logic [WIDTH-1:0] r_imag [DEPTH];

  logic [1:0]      w_eff_mode;
  logic            w_eff_bitrev;
  logic [IDXW-1:0] w_slot;
  logic            w_last;

  // The first sample of a frame uses the live mode/bitrev inputs (they are
  // latched on that same edge); every later sample uses the latched copy.
  always_comb begin
    w_eff_mode   = (r_count == '0) ? mode      : r_mode;
    w_eff_bitrev = (r_count == '0) ? bitrev_en : r_bitrev;
    w_last       = ({1'b0, r_count} == (fft_len(w_eff_mode) - 5'd1));
  end

  fft_bitrev_index u_bitrev_index (
    .count     (r_count),
    .mode      (w_eff_mode),
    .bitrev_en (w_eff_bitrev),
    .slot      (w_slot)
  );

  // Collect/hold FSM with counter, slot buffer and registered handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_COLLECT;
      r_count       <= '0;
      r_mode        <= MODE_N4;
      r_bitrev      <= 1'b0;
      r_in_ready    <= 1'b1;
      r_frame_valid <= 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        r_real[j] <= '0;
        r_imag[j] <= '0;
      end
    end else begin
      case (r_state)
        ST_COLLECT: begin
          if (in_valid) begin
            if (r_count == '0) begin
              r_mode   <= mode;
              r_bitrev <= bitrev_en;
            end
            r_real[w_slot] <= in_real;
            r_imag[w_slot] <= in_imag;
            if (w_last) begin
              r_count       <= '0;
              r_state       <= ST_HOLD;
              r_in_ready    <= 1'b0;
              r_frame_valid <= 1'b1;
            end else begin
              r_count <= r_count + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          // Clearing on hand-off keeps unused slots of short frames at zero.
          if (frame_ready) begin
            r_state       <= ST_COLLECT;
            r_in_ready    <= 1'b1;
            r_frame_valid <= 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
              r_real[j] <= '0;
              r_imag[j] <= '0;
            end
          end
        end
        default: r_state <= ST_COLLECT;
      endcase
    end
  end

  generate
    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
      assign frame_real[g*WIDTH +: WIDTH] = r_real[g];
      assign frame_imag[g*WIDTH +: WIDTH] = r_imag[g];
    end
  endgenerate

  assign in_ready    = r_in_ready;
  assign frame_valid = r_frame_valid;
  assign frame_mode  = r_mode;

endmodule

// File: doc/fft_frame_collector.md
Name: fft_frame_collector

Overview:
- Upstream neighbour of the FFT input register bank.
- Accepts a serial stream of complex samples over a valid/ready handshake.
- Assembles them into one flattened DEPTH-slot frame, in natural or bit-reversed slot order, for FFT lengths 4/8/16.
- Presents the frame with frame_valid until the register bank accepts it; the bank's write enable is frame_valid & frame_ready.

Parameters:
- WIDTH, 16: bits per real/imag component, two's complement.
- DEPTH, 16: frame slots. Fixed at 16 for this design; localparam IDXW = 4.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  input sample valid
- in_ready  output  1  collector can accept a sample
- in_real  input  WIDTH  sample real part, signed
- in_imag  input  WIDTH  sample imag part, signed
- mode  input  2  FFT length select: 00=4, 01=8, 10=16, 11=16 (reserved alias)
- bitrev_en  input  1  1 = place samples at bit-reversed slot index
- frame_valid  output  1  complete frame held on frame_real/frame_imag
- frame_ready  input  1  downstream accepts frame this cycle
- frame_real  output  WIDTH*DEPTH  flattened real slots; slot j at bits [(j+1)*WIDTH-1 -: WIDTH]
- frame_imag  output  WIDTH*DEPTH  flattened imag slots, same packing
- frame_mode  output  2  mode latched for the held frame

Behaviour:
- Reset (async, rst_n=0):
  - state=COLLECT, count=0, all slots=0.
  - in_ready=1 after reset release; frame_valid=0; frame_mode=00.
  - Any partial frame is discarded.
- States COLLECT and HOLD:
  - in_ready = (state==COLLECT); frame_valid = (state==HOLD). Both are registered-state decodes, never combinational from inputs.
- COLLECT:
  - A sample is accepted on a cycle with in_valid & in_ready.
  - When count==0 at acceptance, mode and bitrev_en are latched (N = 4/8/16) and used for the whole frame. Changes mid-frame are ignored.
  - Slot index = count if bitrev_en latched 0; otherwise reverse of count's low log2(N) bits.
  - The accepted sample is written to that slot; count increments.
  - On acceptance of sample N-1: count←0, state←HOLD next cycle.
  - frame_ready is ignored while in COLLECT.
- HOLD:
  - in_ready=0; frame outputs and frame_mode stay stable.
  - On frame_valid & frame_ready, next cycle: state←COLLECT, all slots cleared to 0, frame_valid=0.
  - Slots ≥N therefore read 0 for N<16 frames, because the buffer is zero at every frame start.
- Latency and throughput:
  - frame_valid rises the cycle after the last sample is accepted.
  - Minimum frame period is N+1 cycles (N accept cycles + 1 HOLD cycle with frame_ready=1).
- in_valid gaps inside COLLECT stall count with no other effect.
- Data passes through unmodified: no scaling, rounding or sign changes.

Decomposition:
- Shared package fft_pkg:
  - WIDTH default
  - mode encodings MODE_N4=2'b00, MODE_N8=2'b01, MODE_N16=2'b10
  - function fft_len(mode)
  - function bit_reverse(idx, log2n)
- One natural sub-module: fft_bitrev_index (combinational). Inputs count[3:0], mode, bitrev_en; output slot[3:0]. Reused later by the output reorder stage.
- The collector holds the FSM, counter, slot registers and handshake.

Test Plan:
- N=16, bitrev_en=0, samples real=k, imag=-k for k=0..15, frame_ready=1 → frame_valid one cycle after 16th accept; slot j real=j, imag=-j; in_ready=0 for exactly one cycle.
- N=8, bitrev_en=1, real=k for k=0..7 → slots 0..7 real = 0,4,2,6,1,5,3,7; slots 8..15 = 0; frame_mode=01.
- N=4, bitrev_en=1, real=10..13 → slots 0..3 = 10,12,11,13; frame_ready held 0 for 5 cycles → frame stable, in_ready=0, in_valid ignored; first sample after release lands in a zeroed buffer.
- Back-to-back N=16 frames, in_valid=1 continuously, frame_ready=1 → exactly 17-cycle period; mode toggled to 00 at sample 5 → no effect until next frame start.
- rst_n pulsed low at sample 9 of an N=16 frame → next cycle all slots 0, frame_valid=0, in_ready=1; next frame collects cleanly from slot 0.
- in_valid with random gaps (≈50% duty), N=8, bitrev_en=0 → identical frame contents to the gap-free case; frame_valid only after the 8th accepted sample.
